cr_tlvp_ib_splt: RTL and testbench

Inbound TLV splitter, the receive-side counterpart of the outbound TLV reassembler. It reads the AXI4-stream data-path words (`axi4s_dp_bus_t`) from an upstream FIFO and parses TLV headers. Each word is tagged as a `tlvp_if_bus_t` with `sot`, `eot`, `typen` and `ordern`. Each TLV is routed whole to either the user (engine) path or the passthrough path, selected by TLV type, and framing/BIP2 errors are flagged. It sits between the inbound data-path FIFO and the engine's TLV consumer and passthrough FIFOs.

---
 rtl/cr_tlvp_ib_splt.sv | 199 +++++++++++++++++++
 tb/tb_cr_tlvp_ib_splt.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_tlvp_ib_splt.sv
// Inbound TLV splitter: parses TLV headers from the inbound data-path FIFO,
// tags every word with sot/eot/typen/ordern and routes each TLV whole to the
// user or passthrough FIFO. Framing, length and header BIP2 errors pulse
// alongside the offending word's output write.
`ifndef TLVP_ORD_NUM_WIDTH
`define TLVP_ORD_NUM_WIDTH 4
`endif

module cr_tlvp_ib_splt #(
  parameter logic [31:0] USR_TYPE_MASK = 32'h0000_0000,
  parameter bit          CHK_BIP2      = 1'b1,
  localparam int unsigned ORD_W  = `TLVP_ORD_NUM_WIDTH,
  localparam int unsigned IB_W   = 85,
  localparam int unsigned TLVP_W = IB_W + ORD_W + 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ib_empty,
  input  logic [IB_W-1:0]   ib_tlv,
  output logic              ib_rd,
  input  logic              usr_ib_afull,
  output logic              usr_ib_wr,
  output logic [TLVP_W-1:0] usr_ib_tlv,
  input  logic              pt_ib_afull,
  output logic              pt_ib_wr,
  output logic [TLVP_W-1:0] pt_ib_tlv,
  output logic              err_bip2,
  output logic              err_len,
  output logic              err_frm
);

  typedef struct packed {
    logic        tlast;
    logic [3:0]  tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic             insert;
    logic [ORD_W-1:0] ordern;
    logic [7:0]       typen;
    logic             sot;
    logic             eot;
    logic             tlast;
    logic [3:0]       tid;
    logic [7:0]       tstrb;
    logic [7:0]       tuser;
    logic [63:0]      tdata;
  } tlvp_if_bus_t;

  typedef enum logic {ST_HDR, ST_BODY} state_e;

  localparam logic [ORD_W-1:0] ORD_ONE = ORD_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       type_q, type_d;
  logic             dst_usr_q, dst_usr_d;
  logic [ORD_W-1:0] ord_q, ord_d;
  logic             usr_wr_q, usr_wr_d;
  logic             pt_wr_q, pt_wr_d;
  tlvp_if_bus_t     usr_tlv_q, usr_tlv_d;
  tlvp_if_bus_t     pt_tlv_q, pt_tlv_d;
  logic             err_bip2_q, err_bip2_d;
  logic             err_len_q, err_len_d;
  logic             err_frm_q, err_frm_d;

  axi4s_dp_bus_t    ib_w;
  logic [7:0]       hdr_type;
  logic [7:0]       hdr_len;
  logic [7:0]       hdr_rem;
  logic [7:0]       body_rem;
  logic             hdr_usr;
  logic             bip_even;
  logic             bip_odd;
  logic             bip_bad;

  logic             in_hdr;
  logic [7:0]       cur_rem;
  logic             cur_usr;
  logic             word_eot;
  tlvp_if_bus_t     ow;

  assign ib_w  = axi4s_dp_bus_t'(ib_tlv);
  assign ib_rd = rst_n & ~ib_empty & ~usr_ib_afull & ~pt_ib_afull;

  // Header field decode, destination lookup and BIP2 over {2'b00, tdata[61:0]}
  always_comb begin
    hdr_type = ib_w.tdata[7:0];
    hdr_len  = ib_w.tdata[15:8];
    // A zero length is handled as a one-word TLV.
    hdr_rem  = (hdr_len == 8'd0) ? 8'd0 : hdr_len - 8'd1;
    body_rem = rem_q - 8'd1;
    hdr_usr  = (hdr_type < 8'd32) && USR_TYPE_MASK[hdr_type[4:0]];
    bip_even = ^(ib_w.tdata[61:0] & 62'h1555_5555_5555_5555);
    bip_odd  = ^(ib_w.tdata[61:0] & 62'h2AAA_AAAA_AAAA_AAAA);
    bip_bad  = CHK_BIP2 && (ib_w.tdata[63:62] != {bip_odd, bip_even});
  end

  // Next-state: parse the popped word, tag it and steer it to one destination
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    type_d     = type_q;
    dst_usr_d  = dst_usr_q;
    ord_d      = ord_q;
    usr_wr_d   = 1'b0;
    pt_wr_d    = 1'b0;
    usr_tlv_d  = usr_tlv_q;
    pt_tlv_d   = pt_tlv_q;
    err_bip2_d = 1'b0;
    err_len_d  = 1'b0;
    err_frm_d  = 1'b0;

    in_hdr   = (state_q == ST_HDR);
    cur_rem  = in_hdr ? hdr_rem : body_rem;
    cur_usr  = in_hdr ? hdr_usr : dst_usr_q;
    word_eot = (cur_rem == 8'd0) | ib_w.tlast;

    ow        = '0;
    ow.insert = 1'b0;
    ow.ordern = ord_q;
    ow.typen  = in_hdr ? hdr_type : type_q;
    ow.sot    = in_hdr;
    ow.eot    = word_eot;
    ow.tlast  = ib_w.tlast;
    ow.tid    = ib_w.tid;
    ow.tstrb  = ib_w.tstrb;
    ow.tuser  = ib_w.tuser;
    ow.tdata  = ib_w.tdata;

    if (ib_rd) begin
      rem_d   = cur_rem;
      state_d = word_eot ? ST_HDR : ST_BODY;
      if (in_hdr) begin
        type_d     = hdr_type;
        dst_usr_d  = hdr_usr;
        err_bip2_d = bip_bad;
        err_frm_d  = ~ib_w.tuser[0];
        err_len_d  = (hdr_len == 8'd0) | (ib_w.tlast & (hdr_rem != 8'd0));
      end else begin
        err_frm_d  = ib_w.tuser[0];
        err_len_d  = ib_w.tlast & (body_rem != 8'd0);
      end
      if (word_eot) begin
        ord_d = ib_w.tlast ? ORD_ONE : ord_q + ORD_ONE;
      end
      if (cur_usr) begin
        usr_wr_d  = 1'b1;
        usr_tlv_d = ow;
      end else begin
        pt_wr_d  = 1'b1;
        pt_tlv_d = ow;
      end
    end
  end

  // State and registered outputs; reset discards any partial TLV
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_HDR;
      rem_q      <= '0;
      type_q     <= '0;
      dst_usr_q  <= 1'b0;
      ord_q      <= ORD_ONE;
      usr_wr_q   <= 1'b0;
      pt_wr_q    <= 1'b0;
      usr_tlv_q  <= '0;
      pt_tlv_q   <= '0;
      err_bip2_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_frm_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      type_q     <= type_d;
      dst_usr_q  <= dst_usr_d;
      ord_q      <= ord_d;
      usr_wr_q   <= usr_wr_d;
      pt_wr_q    <= pt_wr_d;
      usr_tlv_q  <= usr_tlv_d;
      pt_tlv_q   <= pt_tlv_d;
      err_bip2_q <= err_bip2_d;
      err_len_q  <= err_len_d;
      err_frm_q  <= err_frm_d;
    end
  end

  assign usr_ib_wr  = usr_wr_q;
  assign pt_ib_wr   = pt_wr_q;
  assign usr_ib_tlv = usr_tlv_q;
  assign pt_ib_tlv  = pt_tlv_q;
  assign err_bip2   = err_bip2_q;
  assign err_len    = err_len_q;
  assign err_frm    = err_frm_q;

endmodule

// File: tb/tb_cr_tlvp_ib_splt.sv
// Bench for cr_tlvp_ib_splt: an upstream FIFO model feeds both a BIP2-checking
// and a non-checking instance; expected tagged words are queued as stimulus is
// pushed and compared as each output write appears.
`ifndef TLVP_ORD_NUM_WIDTH
`define TLVP_ORD_NUM_WIDTH 4
`endif

module tb_cr_tlvp_ib_splt;

  localparam int unsigned ORD_W  = `TLVP_ORD_NUM_WIDTH;
  localparam int unsigned IB_W   = 85;
  localparam int unsigned TLVP_W = IB_W + ORD_W + 11;

  typedef struct packed {
    logic        tlast;
    logic [3:0]  tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic             insert;
    logic [ORD_W-1:0] ordern;
    logic [7:0]       typen;
    logic             sot;
    logic             eot;
    logic             tlast;
    logic [3:0]       tid;
    logic [7:0]       tstrb;
    logic [7:0]       tuser;
    logic [63:0]      tdata;
  } tlvp_if_bus_t;

  typedef struct {
    logic         usr;
    tlvp_if_bus_t w;
    logic         ebip;
    logic         elen;
    logic         efrm;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ib_empty;
  axi4s_dp_bus_t     ib_tlv;
  logic              ib_rd, ib_rd_nc;
  logic              usr_ib_afull = 1'b0;
  logic              pt_ib_afull = 1'b0;
  logic              usr_ib_wr, pt_ib_wr, usr_ib_wr_nc, pt_ib_wr_nc;
  logic [TLVP_W-1:0] usr_ib_tlv, pt_ib_tlv, usr_ib_tlv_nc, pt_ib_tlv_nc;
  logic              err_bip2, err_len, err_frm;
  logic              err_bip2_nc, err_len_nc, err_frm_nc;

  axi4s_dp_bus_t     src_q[$];
  exp_t              exp_q[$];
  int unsigned       test_cnt = 0;
  int unsigned       fail_cnt = 0;
  logic              pop_last = 1'b0;
  logic              mon_en = 1'b0;

  cr_tlvp_ib_splt #(.USR_TYPE_MASK(32'h0000_0020), .CHK_BIP2(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ib_empty(ib_empty), .ib_tlv(ib_tlv), .ib_rd(ib_rd),
    .usr_ib_afull(usr_ib_afull), .usr_ib_wr(usr_ib_wr), .usr_ib_tlv(usr_ib_tlv),
    .pt_ib_afull(pt_ib_afull), .pt_ib_wr(pt_ib_wr), .pt_ib_tlv(pt_ib_tlv),
    .err_bip2(err_bip2), .err_len(err_len), .err_frm(err_frm)
  );

  cr_tlvp_ib_splt #(.USR_TYPE_MASK(32'h0000_0020), .CHK_BIP2(1'b0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .ib_empty(ib_empty), .ib_tlv(ib_tlv), .ib_rd(ib_rd_nc),
    .usr_ib_afull(usr_ib_afull), .usr_ib_wr(usr_ib_wr_nc), .usr_ib_tlv(usr_ib_tlv_nc),
    .pt_ib_afull(pt_ib_afull), .pt_ib_wr(pt_ib_wr_nc), .pt_ib_tlv(pt_ib_tlv_nc),
    .err_bip2(err_bip2_nc), .err_len(err_len_nc), .err_frm(err_frm_nc)
  );

  always #5 clk = ~clk;

  // Header BIP2: bit 0 = parity of even bits, bit 1 = parity of odd bits of {2'b00, d[61:0]}
  function automatic logic [1:0] bip2(input logic [63:0] d);
    logic [1:0] b = 2'b00;
    for (int i = 0; i < 62; i++) begin
      if (d[i]) b[i % 2] = ~b[i % 2];
    end
    return b;
  endfunction

  function automatic axi4s_dp_bus_t mk_hdr(input logic [7:0] typ, input logic [7:0] len,
                                           input logic last, input logic u0, input logic good);
    axi4s_dp_bus_t w;
    logic [1:0] b;
    w.tdata       = {$urandom(), $urandom()};
    w.tdata[7:0]  = typ;
    w.tdata[15:8] = len;
    b = bip2(w.tdata);
    w.tdata[63:62] = good ? b : ~b;
    w.tuser    = 8'($urandom());
    w.tuser[0] = u0;
    w.tstrb    = 8'hFF;
    w.tid      = 4'($urandom());
    w.tlast    = last;
    return w;
  endfunction

  function automatic axi4s_dp_bus_t mk_body(input logic last, input logic u0);
    axi4s_dp_bus_t w;
    w.tdata    = {$urandom(), $urandom()};
    w.tuser    = 8'($urandom());
    w.tuser[0] = u0;
    w.tstrb    = 8'($urandom());
    w.tid      = 4'($urandom());
    w.tlast    = last;
    return w;
  endfunction

  task automatic push(input axi4s_dp_bus_t w, input logic usr, input logic sot, input logic eot,
                      input logic [ORD_W-1:0] ord, input logic [7:0] typ,
                      input logic eb, input logic el, input logic ef);
    exp_t e;
    e.usr = usr; e.ebip = eb; e.elen = el; e.efrm = ef;
    e.w.insert = 1'b0;    e.w.ordern = ord;     e.w.typen = typ;
    e.w.sot    = sot;     e.w.eot    = eot;     e.w.tlast = w.tlast;
    e.w.tid    = w.tid;   e.w.tstrb  = w.tstrb; e.w.tuser = w.tuser;
    e.w.tdata  = w.tdata;
    src_q.push_back(w);
    exp_q.push_back(e);
  endtask

  // Upstream FIFO model: pop on a sampled ib_rd, present the new head shortly after the edge
  initial begin
    axi4s_dp_bus_t tmp;
    ib_empty = 1'b1;
    ib_tlv   = '0;
    forever begin
      @(posedge clk);
      pop_last = ib_rd;
      #1;
      if (pop_last && src_q.size() != 0) tmp = src_q.pop_front();
      ib_empty = (src_q.size() == 0);
      ib_tlv   = ib_empty ? '0 : src_q[0];
    end
  end

  // Output monitor: read gating, one-cycle latency, and scoreboard comparison on every write
  initial begin
    exp_t e;
    logic exp_rd;
    logic [TLVP_W-1:0] got, got_nc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_rd = rst_n & ~ib_empty & ~usr_ib_afull & ~pt_ib_afull;
        test_cnt++;
        if (ib_rd !== exp_rd || ib_rd_nc !== exp_rd) begin
          fail_cnt++;
          $display("FAIL ib_rd: got %b/%b required %b", ib_rd, ib_rd_nc, exp_rd);
        end
        test_cnt++;
        if ((usr_ib_wr | pt_ib_wr) !== pop_last) begin
          fail_cnt++;
          $display("FAIL latency: write got %b required %b", usr_ib_wr | pt_ib_wr, pop_last);
        end
        if (usr_ib_wr === 1'b1 && pt_ib_wr === 1'b1) begin
          fail_cnt++;
          $display("FAIL dual_wr: got usr=1 pt=1 required one-hot");
        end
        if ((usr_ib_wr | pt_ib_wr) === 1'b1) begin
          test_cnt++;
          if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL unexpected_wr: got write with empty scoreboard required none");
          end else begin
            e = exp_q.pop_front();
            got    = usr_ib_wr ? usr_ib_tlv : pt_ib_tlv;
            got_nc = usr_ib_wr_nc ? usr_ib_tlv_nc : pt_ib_tlv_nc;
            if ({usr_ib_wr, pt_ib_wr} !== {e.usr, ~e.usr}) begin
              fail_cnt++;
              $display("FAIL dest: got usr=%b pt=%b required usr=%b", usr_ib_wr, pt_ib_wr, e.usr);
            end
            test_cnt++;
            if (got !== e.w) begin
              fail_cnt++;
              $display("FAIL word: got %h required %h", got, e.w);
            end
            test_cnt++;
            if ({err_bip2, err_len, err_frm} !== {e.ebip, e.elen, e.efrm}) begin
              fail_cnt++;
              $display("FAIL errs: got bip/len/frm=%b%b%b required %b%b%b",
                       err_bip2, err_len, err_frm, e.ebip, e.elen, e.efrm);
            end
            test_cnt++;
            if ({usr_ib_wr_nc, pt_ib_wr_nc} !== {e.usr, ~e.usr} || got_nc !== e.w ||
                {err_bip2_nc, err_len_nc, err_frm_nc} !== {1'b0, e.elen, e.efrm}) begin
              fail_cnt++;
              $display("FAIL nochk: got usr=%b word=%h errs=%b%b%b required usr=%b word=%h errs=0%b%b",
                       usr_ib_wr_nc, got_nc, err_bip2_nc, err_len_nc, err_frm_nc,
                       e.usr, e.w, e.elen, e.efrm);
            end
          end
        end else begin
          test_cnt++;
          if ({err_bip2, err_len, err_frm, err_bip2_nc, err_len_nc, err_frm_nc} !== 6'b0) begin
            fail_cnt++;
            $display("FAIL idle_errs: got %b%b%b/%b%b%b required 000/000",
                     err_bip2, err_len, err_frm, err_bip2_nc, err_len_nc, err_frm_nc);
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int unsigned n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    test_cnt++;
    if (src_q.size() != 0 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL %s_drain: got src=%0d exp=%0d left required 0/0", name, src_q.size(), exp_q.size());
      src_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input int unsigned ncyc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (ncyc) begin
      @(posedge clk); #2;
      test_cnt++;
      if ({usr_ib_wr, pt_ib_wr, err_bip2, err_len, err_frm, ib_rd} !== 6'b0 ||
          usr_ib_tlv !== '0 || pt_ib_tlv !== '0) begin
        fail_cnt++;
        $display("FAIL reset_outputs: got wr=%b%b err=%b%b%b rd=%b tlv=%h/%h required all 0",
                 usr_ib_wr, pt_ib_wr, err_bip2, err_len, err_frm, ib_rd, usr_ib_tlv, pt_ib_tlv);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    push(mk_hdr(8'd7, 8'd1, 1'b1, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, ORD_W'(1), 8'd7, 1'b0, 1'b0, 1'b0);
    do_reset(3);
    drain("reset");
  endtask

  task automatic test_two_tlv();
    push(mk_hdr(8'd3, 8'd2, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0, ORD_W'(1), 8'd3, 1'b0, 1'b0, 1'b0);
    push(mk_body(1'b0, 1'b0),                 1'b0, 1'b0, 1'b1, ORD_W'(1), 8'd3, 1'b0, 1'b0, 1'b0);
    push(mk_hdr(8'd5, 8'd1, 1'b1, 1'b1, 1'b1), 1'b1, 1'b1, 1'b1, ORD_W'(2), 8'd5, 1'b0, 1'b0, 1'b0);
    push(mk_hdr(8'd7, 8'd1, 1'b1, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, ORD_W'(1), 8'd7, 1'b0, 1'b0, 1'b0);
    drain("two_tlv");
  endtask

  task automatic test_stall();
    push(mk_hdr(8'd5, 8'd4, 1'b0, 1'b1, 1'b1), 1'b1, 1'b1, 1'b0, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b0);
    push(mk_body(1'b0, 1'b0),                 1'b1, 1'b0, 1'b0, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b0);
    push(mk_body(1'b0, 1'b0),                 1'b1, 1'b0, 1'b0, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b0);
    push(mk_body(1'b1, 1'b0),                 1'b1, 1'b0, 1'b1, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      pt_ib_afull = ~pt_ib_afull;
      #1;
      test_cnt++;
      if (ib_rd !== (~pt_ib_afull & ~ib_empty)) begin
        fail_cnt++;
        $display("FAIL stall_rd: got %b required %b (afull=%b)", ib_rd, ~pt_ib_afull & ~ib_empty, pt_ib_afull);
      end
    end
    pt_ib_afull = 1'b0;
    drain("stall");
  endtask

  task automatic test_trunc();
    push(mk_hdr(8'd3, 8'd4, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0, ORD_W'(1), 8'd3, 1'b0, 1'b0, 1'b0);
    push(mk_body(1'b1, 1'b0),                 1'b0, 1'b0, 1'b1, ORD_W'(1), 8'd3, 1'b0, 1'b1, 1'b0);
    push(mk_hdr(8'd3, 8'd1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, ORD_W'(1), 8'd3, 1'b0, 1'b0, 1'b0);
    push(mk_hdr(8'd6, 8'd0, 1'b1, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, ORD_W'(2), 8'd6, 1'b0, 1'b1, 1'b0);
    drain("trunc");
  endtask

  task automatic test_frm();
    push(mk_hdr(8'd5, 8'd2, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b1);
    push(mk_body(1'b1, 1'b1),                 1'b1, 1'b0, 1'b1, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b1);
    drain("frm");
  endtask

  task automatic test_bip2();
    push(mk_hdr(8'd5, 8'd1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, ORD_W'(1), 8'd5, 1'b1, 1'b0, 1'b0);
    push(mk_hdr(8'd5, 8'd1, 1'b1, 1'b1, 1'b1), 1'b1, 1'b1, 1'b1, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b0);
    drain("bip2");
  endtask

  task automatic test_back_to_back();
    usr_ib_afull = 1'b1;
    push(mk_hdr(8'd5,  8'd1, 1'b0, 1'b1, 1'b1), 1'b1, 1'b1, 1'b1, ORD_W'(1), 8'd5,  1'b0, 1'b0, 1'b0);
    push(mk_hdr(8'd37, 8'd1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, ORD_W'(2), 8'd37, 1'b0, 1'b0, 1'b0);
    push(mk_hdr(8'd5,  8'd2, 1'b0, 1'b1, 1'b1), 1'b1, 1'b1, 1'b0, ORD_W'(3), 8'd5,  1'b0, 1'b0, 1'b0);
    push(mk_body(1'b1, 1'b0),                  1'b1, 1'b0, 1'b1, ORD_W'(3), 8'd5,  1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    test_cnt++;
    if (src_q.size() != 4) begin
      fail_cnt++;
      $display("FAIL usr_afull_hold: got %0d words left required 4", src_q.size());
    end
    usr_ib_afull = 1'b0;
    drain("back_to_back");
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 17; i++)
      push(mk_hdr(8'd9, 8'd1, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 1'b1, ORD_W'(i + 1), 8'd9, 1'b0, 1'b0, 1'b0);
    drain("wrap");
    push(mk_hdr(8'd3, 8'd4, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0, ORD_W'(2), 8'd3, 1'b0, 1'b0, 1'b0);
    push(mk_body(1'b0, 1'b0),                 1'b0, 1'b0, 1'b0, ORD_W'(2), 8'd3, 1'b0, 1'b0, 1'b0);
    drain("pre_reset");
    push(mk_hdr(8'd5, 8'd2, 1'b0, 1'b1, 1'b1), 1'b1, 1'b1, 1'b0, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b0);
    push(mk_body(1'b1, 1'b0),                 1'b1, 1'b0, 1'b1, ORD_W'(1), 8'd5, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    drain("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish before 200000");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    mon_en = 1'b1;
    test_reset();
    test_two_tlv();
    test_stall();
    test_trunc();
    test_frm();
    test_bip2();
    test_back_to_back();
    test_wrap_reset();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
